// File: rtl/sp_pkg.sv
// Shared pipeline parameters for the fetch front end.
package sp_pkg;

   // Width of every instruction address in the pipeline.
   localparam int ADDR_WIDTH = 32;

endpackage : sp_pkg

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter generation stage feeding instruction_fetch.
// Advances the PC on each accepted fetch, holds it on stall, and handles
// control-flow redirects. A redirect that arrives while a request is still
// outstanding parks its target in a pending register (DRAIN). The PC then
// waits for the in-flight wrong-path ack, kills it, and jumps.
//
// Optional build macro: PC_MISALIGN_CHK_EN
//   defined   - redirects with nonzero low target bits are rejected. The
//               rejection raises a one-cycle registered misalign_o pulse.
//   undefined - low target bits are cleared silently, and misalign_o is 0.
module pc_sequencer
   import sp_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned           PC_STEP  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  imem_ack_i,
   input  logic                  stall_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  pc_valid_o,
   output logic                  kill_o,
   output logic                  misalign_o
);

   // Number of PC low bits that are always zero; derived from the step size.
   localparam int unsigned ALIGN_BITS = $clog2(PC_STEP);
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
      ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

   typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

   state_t                  state_reg;
   logic [ADDR_WIDTH-1:0]   pc_reg;
   logic                    pc_valid_reg;
   logic [ADDR_WIDTH-1:0]   pending_reg;
   logic [ADDR_WIDTH-1:0]   target;
   logic                    redirect_ok;
   logic                    misalign_hit;

   assign target = redirect_addr_i & ~LOW_MASK;

`ifdef PC_MISALIGN_CHK_EN
   logic misalign_reg;

   // A misaligned redirect is treated as if no redirect had been requested.
   assign misalign_hit = redirect_i && ((redirect_addr_i & LOW_MASK) != '0);
   assign redirect_ok  = redirect_i && !misalign_hit;
   assign misalign_o   = misalign_reg;

   // Flag a rejected redirect one cycle later. Redirects in BOOT are ignored.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         misalign_reg <= 1'b0;
      end else begin
         misalign_reg <= misalign_hit && (state_reg != BOOT);
      end
   end
`else
   assign misalign_hit = 1'b0;
   assign redirect_ok  = redirect_i && !misalign_hit;
   assign misalign_o   = 1'b0;
`endif

   // The acked instruction is on the wrong path if a redirect lands on its ack,
   // or if the ack completes a request already marked stale by DRAIN.
   always_comb begin
      kill_o = 1'b0;
      if (rst_ni && imem_ack_i) begin
         case (state_reg)
            FETCH:   kill_o = redirect_ok;
            DRAIN:   kill_o = 1'b1;
            default: kill_o = 1'b0;
         endcase
      end
   end

   // Sequencer state, PC, and pending redirect target.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg    <= BOOT;
         pc_reg       <= RESET_PC;
         pc_valid_reg <= 1'b0;
         pending_reg  <= '0;
      end else begin
         case (state_reg)
            BOOT: begin
               state_reg    <= FETCH;
               pc_valid_reg <= 1'b1;
            end
            FETCH: begin
               if (redirect_ok && imem_ack_i) begin
                  pc_reg <= target;
               end else if (redirect_ok) begin
                  pending_reg <= target;
                  state_reg   <= DRAIN;
               end else if (imem_ack_i && !stall_i) begin
                  pc_reg <= pc_reg + STEP;
               end
            end
            DRAIN: begin
               // Stall is ignored here because the acked instruction is discarded anyway.
               if (imem_ack_i) begin
                  pc_reg    <= redirect_ok ? target : pending_reg;
                  state_reg <= FETCH;
               end else if (redirect_ok) begin
                  pending_reg <= target;
               end
            end
            default: begin
               state_reg    <= BOOT;
               pc_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign pc_o       = pc_reg;
   assign pc_valid_o = pc_valid_reg;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (default parameters, 32-bit addresses).
// Inputs change 1 time unit after a rising edge. kill_o is checked once the
// inputs settle. Registered outputs are checked after the next edge.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ack;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic [31:0] pc;
   logic        pc_valid;
   logic        kill;
   logic        misalign;

   int tests_run = 0;
   int tests_failed = 0;

   pc_sequencer dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .imem_ack_i      (ack),
      .stall_i         (stall),
      .redirect_i      (redirect),
      .redirect_addr_i (redirect_addr),
      .pc_o            (pc),
      .pc_valid_o      (pc_valid),
      .kill_o          (kill),
      .misalign_o      (misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Apply one cycle of inputs and let combinational outputs settle.
   task automatic drive(input logic r_n, input logic a, input logic s,
                        input logic r, input logic [31:0] addr);
      rst_n         = r_n;
      ack           = a;
      stall         = s;
      redirect      = r;
      redirect_addr = addr;
      #1;
   endtask

   // Advance past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
      tick();
      tick();
      check("rst_kill", {31'd0, kill}, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'd0, pc_valid}, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);

      // BOOT cycle: inputs ignored.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
      check("boot_kill", {31'd0, kill}, 32'd0);
      check("boot_valid", {31'd0, pc_valid}, 32'd0);
      tick();
      check("boot_pc", pc, 32'h0);
      check("fetch_valid", {31'd0, pc_valid}, 32'd1);

      // Free-running fetch.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("seq_kill", {31'd0, kill}, 32'd0);
      tick();
      check("seq_pc4", pc, 32'h4);
      tick();
      check("seq_pc8", pc, 32'h8);

      // Stall holds the PC.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         check("stall_kill", {31'd0, kill}, 32'd0);
         tick();
         check("stall_pc", pc, 32'h8);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check("unstall_pc", pc, 32'hC);
      tick();
      check("seq_pc10", pc, 32'h10);

      // Redirect together with ack, with stall also asserted: redirect has priority.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
      check("redir_ack_kill", {31'd0, kill}, 32'd1);
      tick();
      check("redir_ack_pc", pc, 32'h40);

      // Redirects while the request is outstanding; the latest target wins.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
      check("drain1_kill", {31'd0, kill}, 32'd0);
      tick();
      check("drain1_pc", pc, 32'h40);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hA0);
      check("drain2_kill", {31'd0, kill}, 32'd0);
      tick();
      check("drain2_pc", pc, 32'h40);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      check("drain3_kill", {31'd0, kill}, 32'd0);
      tick();
      check("drain3_pc", pc, 32'h40);
      check("drain_valid", {31'd0, pc_valid}, 32'd1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check("drain_ack_kill", {31'd0, kill}, 32'd1);
      tick();
      check("drain_ack_pc", pc, 32'hA0);

      // Without an ack the same address is fetched again.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("noack_kill", {31'd0, kill}, 32'd0);
      tick();
      check("noack_pc", pc, 32'hA0);

      // The PC wraps from the top of the address space back to 0.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      tick();
      check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check("wrap_pc", pc, 32'h0);

      // Misaligned redirect to 0x42.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h42);
`ifdef PC_MISALIGN_CHK_EN
      check("mis_kill", {31'd0, kill}, 32'd0);
      tick();
      check("mis_pc", pc, 32'h4);
      check("mis_flag", {31'd0, misalign}, 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check("mis_flag_clear", {31'd0, misalign}, 32'd0);
      check("mis_seq_pc", pc, 32'h8);
`else
      check("mis_kill", {31'd0, kill}, 32'd1);
      tick();
      check("mis_pc", pc, 32'h40);
      check("mis_flag", {31'd0, misalign}, 32'd0);
`endif

      // A reset during DRAIN discards the pending target.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("rst_drain_kill", {31'd0, kill}, 32'd0);
      tick();
      check("rst_drain_pc", pc, 32'h0);
      check("rst_drain_valid", {31'd0, pc_valid}, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("reboot_kill", {31'd0, kill}, 32'd0);
      tick();
      check("reboot_pc", pc, 32'h0);
      check("reboot_valid", {31'd0, pc_valid}, 32'd1);
      check("reboot_fetch_kill", {31'd0, kill}, 32'd0);
      tick();
      check("reboot_seq_pc", pc, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_pc_sequencer
